mem_arbiter: RTL and testbench

- Shares the single 128-bit-block main memory port between the instruction cache (read-only) and the data cache (read/write refill and write-back).
- Sits between both cache controllers and main memory.
- Serialises one block transfer at a time and routes the memory busywait and read data back to the granted requester.
- Supports round-robin or fixed data-cache priority, plus a stuck-transfer watchdog.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/mem_arbiter_if.sv | 22 ++
 rtl/mem_arbiter_arb_rr2.sv | 23 ++
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory arbiter: state encoding,
// requester ids and the block/address widths of the memory port.
package mem_arb_pkg;

    localparam int BLOCK_W = 128;
    localparam int ADDR_W  = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SERVE_I = 2'b01,
        SERVE_D = 2'b10
    } arb_state_t;

    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } grant_id_t;

    function automatic grant_id_t other_id(input grant_id_t id);
        return (id == ICACHE) ? DCACHE : ICACHE;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Block-transfer port: a requester (master) drives the command, the responder
// (slave) returns a block and a busywait stall.
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic               read;
    logic               write;
    logic [ADDR_W-1:0]  address;
    logic [BLOCK_W-1:0] writedata;
    logic [BLOCK_W-1:0] readdata;
    logic               busywait;

    modport master (
        output read, write, address, writedata,
        input  readdata, busywait
    );

    modport slave (
        input  read, write, address, writedata,
        output readdata, busywait
    );
endinterface

// File: rtl/mem_arbiter_arb_rr2.sv
// Two-requester picker: req[0] is the icache, req[1] the dcache. On a tie it
// either alternates away from last_grant or always favours the dcache.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  grant_id_t  last_grant,
    input  logic       round_robin,
    output logic       grant_valid,
    output grant_id_t  grant_id
);

    always_comb begin
        grant_valid = |req;
        grant_id    = ICACHE;
        if (req == 2'b11) begin
            grant_id = round_robin ? other_id(last_grant) : DCACHE;
        end else if (req[1]) begin
            grant_id = DCACHE;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one block-wide memory port between the icache and the dcache, one
// transfer at a time, with a watchdog that aborts a stuck transfer.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ROUND_ROBIN = 1,
    parameter int TIMEOUT     = 255
) (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.slave  ic,
    mem_arbiter_if.slave  dc,
    mem_arbiter_if.master mem,
    output logic          err_timeout
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
    localparam logic       RR_MODE   = (ROUND_ROBIN != 0);

    arb_state_t         state_reg, state_next;
    grant_id_t          last_grant_reg;
    logic [7:0]         timer_reg;
    logic               mem_read_reg, mem_write_reg;
    logic [ADDR_W-1:0]  mem_address_reg;
    logic [BLOCK_W-1:0] mem_writedata_reg;
    logic               err_timeout_reg;

    logic       ic_req, dc_req;
    logic       grant_valid;
    grant_id_t  grant_id;
    logic       serving, done, timed_out;

    // The icache port is read-only; its write side is never looked at.
    logic unused_ic;
    assign unused_ic = ^{ic.write, ic.writedata};

    assign ic_req = ic.read;
    assign dc_req = dc.read | dc.write;

    arb_rr2 u_pick (
        .req         ({dc_req, ic_req}),
        .last_grant  (last_grant_reg),
        .round_robin (RR_MODE),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Memory only raises busywait after sampling the command, so the first
    // serve cycle (timer==0) can never complete the transfer.
    assign serving   = (state_reg != IDLE);
    assign done      = serving && (timer_reg != 8'd0) && !mem.busywait;
    assign timed_out = serving && !done && (timer_reg == TIMEOUT_C);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    state_next = (grant_id == DCACHE) ? SERVE_D : SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                if (done || timed_out) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg         <= IDLE;
            last_grant_reg    <= ICACHE;
            timer_reg         <= 8'd0;
            mem_read_reg      <= 1'b0;
            mem_write_reg     <= 1'b0;
            mem_address_reg   <= '0;
            mem_writedata_reg <= '0;
            err_timeout_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE) begin
                if (grant_valid) begin
                    last_grant_reg <= grant_id;
                    timer_reg      <= 8'd0;
                    if (grant_id == DCACHE) begin
                        // A simultaneous read and write is taken as a write.
                        mem_read_reg      <= !dc.write;
                        mem_write_reg     <= dc.write;
                        mem_address_reg   <= dc.address;
                        mem_writedata_reg <= dc.writedata;
                    end else begin
                        mem_read_reg      <= 1'b1;
                        mem_write_reg     <= 1'b0;
                        mem_address_reg   <= ic.address;
                        mem_writedata_reg <= '0;
                    end
                end
            end else begin
                timer_reg <= timer_reg + 8'd1;
                if (done || timed_out) begin
                    mem_read_reg  <= 1'b0;
                    mem_write_reg <= 1'b0;
                end
                if (timed_out) begin
                    err_timeout_reg <= 1'b1;
                end
            end
        end
    end

    assign mem.read      = mem_read_reg;
    assign mem.write     = mem_write_reg;
    assign mem.address   = mem_address_reg;
    assign mem.writedata = mem_writedata_reg;
    assign err_timeout   = err_timeout_reg;

    assign ic.busywait = ic_req & ~((state_reg == SERVE_I) & done);
    assign dc.busywait = dc_req & ~((state_reg == SERVE_D) & done);
    assign ic.readdata = (state_reg == SERVE_I) ? mem.readdata : '0;
    assign dc.readdata = (state_reg == SERVE_D) ? mem.readdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Two arbiters (round-robin and fixed-priority, both with an 8-cycle watchdog)
// each in front of a behavioural memory, driven by transaction-level requesters.
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic         ic_read_s  [2];
    logic [5:0]   ic_addr_s  [2];
    logic         dc_read_s  [2];
    logic         dc_write_s [2];
    logic [5:0]   dc_addr_s  [2];
    logic [127:0] dc_wdata_s [2];
    int           lat_s      [2];
    bit           stuck_s    [2];
    bit           rand_lat_s [2];

    logic         ic_busy_o   [2];
    logic [127:0] ic_rdata_o  [2];
    logic         dc_busy_o   [2];
    logic [127:0] dc_rdata_o  [2];
    logic         mem_read_o  [2];
    logic         mem_write_o [2];
    logic [5:0]   mem_addr_o  [2];
    logic [127:0] mem_wdata_o [2];
    logic         err_o       [2];

    logic [127:0] ref_mem [2][64];
    int comp_cnt [2][2];
    int seq_cnt  [2];
    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [127:0] init_word(input int a);
        logic [31:0] w;
        if (a == 'h15) return {16{8'hA5}};
        w = 32'hC0DE_0000 | 32'(a);
        return {4{w}};
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        mem_arbiter_if ic_bus ();
        mem_arbiter_if dc_bus ();
        mem_arbiter_if mem_bus ();

        logic [127:0] store [64];
        logic         busy;
        int           phase;
        int           cnt;
        logic [5:0]   addr_l;

        assign ic_bus.read      = ic_read_s[gi];
        assign ic_bus.write     = 1'b0;
        assign ic_bus.address   = ic_addr_s[gi];
        assign ic_bus.writedata = '0;
        assign dc_bus.read      = dc_read_s[gi];
        assign dc_bus.write     = dc_write_s[gi];
        assign dc_bus.address   = dc_addr_s[gi];
        assign dc_bus.writedata = dc_wdata_s[gi];

        assign ic_busy_o[gi]   = ic_bus.busywait;
        assign ic_rdata_o[gi]  = ic_bus.readdata;
        assign dc_busy_o[gi]   = dc_bus.busywait;
        assign dc_rdata_o[gi]  = dc_bus.readdata;
        assign mem_read_o[gi]  = mem_bus.read;
        assign mem_write_o[gi] = mem_bus.write;
        assign mem_addr_o[gi]  = mem_bus.address;
        assign mem_wdata_o[gi] = mem_bus.writedata;

        // Memory: samples a command, stays busy for its latency, then shows
        // the block for one cycle with busywait low.
        assign mem_bus.readdata = store[addr_l];
        assign mem_bus.busywait = busy | stuck_s[gi];

        always @(posedge clk) begin
            if (!rst_n) begin
                phase  <= 0;
                busy   <= 1'b0;
                cnt    <= 0;
                addr_l <= '0;
                for (int a = 0; a < 64; a++) store[a] <= init_word(a);
            end else begin
                case (phase)
                    0: if (mem_bus.read || mem_bus.write) begin
                        addr_l <= mem_bus.address;
                        busy   <= 1'b1;
                        cnt    <= rand_lat_s[gi] ? int'($urandom_range(1, 6)) : lat_s[gi];
                        phase  <= 1;
                        if (mem_bus.write) store[mem_bus.address] <= mem_bus.writedata;
                    end
                    1: if (stuck_s[gi]) begin
                        if (!(mem_bus.read || mem_bus.write)) begin
                            phase <= 0;
                            busy  <= 1'b0;
                        end
                    end else if (cnt <= 1) begin
                        busy  <= 1'b0;
                        phase <= 2;
                    end else begin
                        cnt <= cnt - 1;
                    end
                    default: phase <= 0;
                endcase
            end
        end

        mem_arbiter #(
            .ROUND_ROBIN ((gi == 0) ? 1 : 0),
            .TIMEOUT     (8)
        ) u_dut (
            .clock       (clk),
            .reset       (rst_n),
            .ic          (ic_bus),
            .dc          (dc_bus),
            .mem         (mem_bus),
            .err_timeout (err_o[gi])
        );
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ref_init();
        for (int i = 0; i < 2; i++)
            for (int a = 0; a < 64; a++) ref_mem[i][a] = init_word(a);
    endtask

    // One block transfer from cache c (0=icache, 1=dcache) of instance idx.
    task automatic do_xfer(input int idx, input int c, input bit wr, input logic [5:0] addr,
                           input logic [127:0] wdata, input bit solo,
                           output int cycles, output int order);
        int other_snap;
        bit released;
        logic [127:0] got;
        other_snap = comp_cnt[idx][1-c];
        order = 0;
        if (c == 0) begin
            ic_addr_s[idx] = addr;
            ic_read_s[idx] = 1'b1;
        end else begin
            dc_addr_s[idx]  = addr;
            dc_wdata_s[idx] = wdata;
            dc_write_s[idx] = wr;
            dc_read_s[idx]  = !wr;
        end
        cycles = 0;
        released = 1'b0;
        while (!released && cycles < 2000) begin
            tick();
            cycles++;
            if (solo && cycles == 1) begin
                check_eq("cmd_read", mem_read_o[idx], !wr);
                check_eq("cmd_write", mem_write_o[idx], wr);
                check_eq("cmd_addr", mem_addr_o[idx], addr);
                if (wr) check_eq("cmd_wdata", mem_wdata_o[idx], wdata);
                check_eq("idle_side_busy", (c == 0) ? dc_busy_o[idx] : ic_busy_o[idx], 0);
            end
            released = (c == 0) ? !ic_busy_o[idx] : !dc_busy_o[idx];
        end
        check_eq("released", released, 1);
        if (released) begin
            got = (c == 0) ? ic_rdata_o[idx] : dc_rdata_o[idx];
            if (!wr) check_eq((c == 0) ? "ic_rdata" : "dc_rdata", got, ref_mem[idx][addr]);
            else ref_mem[idx][addr] = wdata;
            seq_cnt[idx]++;
            order = seq_cnt[idx];
            comp_cnt[idx][c]++;
            if (idx == 0) check_eq("rr_no_starve", (comp_cnt[0][1-c] - other_snap) <= 1, 1);
        end
        tick();
        check_eq("cmd_cleared", mem_read_o[idx] | mem_write_o[idx], 0);
        if (c == 0) ic_read_s[idx] = 1'b0;
        else begin
            dc_read_s[idx]  = 1'b0;
            dc_write_s[idx] = 1'b0;
        end
    endtask

    task automatic rand_driver(input int idx, input int c, input int n);
        int cyc, ord, gap;
        bit wr;
        logic [5:0] addr;
        logic [127:0] wdata;
        for (int k = 0; k < n; k++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) tick();
            addr  = 6'($urandom_range(0, 63));
            wr    = (c == 1) && ($urandom_range(0, 1) == 1);
            wdata = {$urandom, $urandom, $urandom, $urandom};
            do_xfer(idx, c, wr, addr, wdata, 1'b0, cyc, ord);
            $display("[TB] inst%0d %s %s addr=%h cycles=%0d", idx, (c == 0) ? "ic" : "dc",
                     wr ? "write" : "read", addr, cyc);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    int cyc_a, ord_a, cyc_b, ord_b, ord_fp_ic, base0, base1;

    initial begin
        for (int i = 0; i < 2; i++) begin
            ic_read_s[i] = 0; ic_addr_s[i] = 0; dc_read_s[i] = 0; dc_write_s[i] = 0;
            dc_addr_s[i] = 0; dc_wdata_s[i] = 0; lat_s[i] = 5; stuck_s[i] = 0;
            rand_lat_s[i] = 0; seq_cnt[i] = 0; comp_cnt[i][0] = 0; comp_cnt[i][1] = 0;
        end
        ref_init();

        // Reset held with an icache request pending.
        rst_n = 1'b0;
        ic_addr_s[0] = 6'h15;
        ic_read_s[0] = 1'b1;
        tick();
        tick();
        check_eq("rst_mem_read", mem_read_o[0], 0);
        check_eq("rst_mem_addr", mem_addr_o[0], 0);
        check_eq("rst_err", err_o[0], 0);
        check_eq("rst_ic_busy", ic_busy_o[0], 1);
        rst_n = 1'b1;

        do_xfer(0, 0, 1'b0, 6'h15, '0, 1'b1, cyc_a, ord_a);
        $display("[TB] inst0 ic read addr=15 cycles=%0d", cyc_a);
        check_eq("ic_lat", cyc_a, lat_s[0] + 2);
        check_eq("ic_a5", ref_mem[0][6'h15], {16{8'hA5}});

        do_xfer(0, 1, 1'b1, 6'h3F, 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 1'b1, cyc_a, ord_a);
        $display("[TB] inst0 dc write addr=3f cycles=%0d", cyc_a);
        check_eq("dc_wr_lat", cyc_a, lat_s[0] + 2);

        do_xfer(0, 0, 1'b0, 6'h3F, '0, 1'b1, cyc_a, ord_a);
        $display("[TB] inst0 ic read addr=3f cycles=%0d", cyc_a);

        // Simultaneous requests: inst0 alternates (last grant icache), inst1 favours dcache.
        base0 = seq_cnt[0];
        base1 = seq_cnt[1];
        fork
            do_xfer(0, 1, 1'b0, 6'h15, '0, 1'b0, cyc_a, ord_a);
            do_xfer(0, 0, 1'b0, 6'h3F, '0, 1'b0, cyc_b, ord_b);
            begin
                int c1, o1;
                for (int k = 0; k < 3; k++) do_xfer(1, 1, 1'b0, 6'(k + 1), '0, 1'b0, c1, o1);
            end
            begin
                int c2;
                do_xfer(1, 0, 1'b0, 6'h15, '0, 1'b0, c2, ord_fp_ic);
            end
        join
        $display("[TB] inst0 tie: dc cycles=%0d order=%0d, ic cycles=%0d order=%0d",
                 cyc_a, ord_a - base0, cyc_b, ord_b - base0);
        check_eq("rr_dc_first", ord_a - base0, 1);
        check_eq("rr_ic_second", ord_b - base0, 2);
        check_eq("rr_dc_lat", cyc_a, lat_s[0] + 2);
        check_eq("rr_one_idle", cyc_b, 2 * lat_s[0] + 5);
        $display("[TB] inst1 tie: ic order=%0d", ord_fp_ic - base1);
        check_eq("fp_dc_wins", ord_fp_ic - base1, 4);

        // Watchdog: memory never drops busywait.
        stuck_s[0] = 1'b1;
        ic_addr_s[0] = 6'h07;
        ic_read_s[0] = 1'b1;
        repeat (9) tick();
        check_eq("to_before_err", err_o[0], 0);
        check_eq("to_before_cmd", mem_read_o[0], 1);
        tick();
        check_eq("to_abort_cmd", mem_read_o[0], 0);
        check_eq("to_err_set", err_o[0], 1);
        check_eq("to_ic_busy", ic_busy_o[0], 1);
        tick();
        check_eq("to_regrant", mem_read_o[0], 1);
        ic_read_s[0] = 1'b0;
        stuck_s[0] = 1'b0;
        repeat (20) tick();
        check_eq("to_err_sticky", err_o[0], 1);
        check_eq("to_settled_cmd", mem_read_o[0], 0);
        $display("[TB] inst0 timeout abort err=%0b", err_o[0]);

        // Reset in the middle of a dcache transfer.
        dc_addr_s[0] = 6'h2A;
        dc_read_s[0] = 1'b1;
        repeat (3) tick();
        check_eq("mid_serving", mem_read_o[0], 1);
        rst_n = 1'b0;
        tick();
        check_eq("mid_rst_read", mem_read_o[0], 0);
        check_eq("mid_rst_write", mem_write_o[0], 0);
        check_eq("mid_rst_rdata", dc_rdata_o[0], 0);
        check_eq("mid_rst_busy", dc_busy_o[0], 1);
        check_eq("mid_rst_err", err_o[0], 0);
        dc_read_s[0] = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        ref_init();
        $display("[TB] inst0 reset mid-transfer done");

        // Random traffic against both arbiters.
        rand_lat_s[0] = 1'b1;
        rand_lat_s[1] = 1'b1;
        fork
            rand_driver(0, 0, 20);
            rand_driver(0, 1, 20);
            rand_driver(1, 0, 20);
            rand_driver(1, 1, 20);
        join
        check_eq("rand_no_timeout0", err_o[0], 0);
        check_eq("rand_no_timeout1", err_o[1], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
